// File: rtl/axi_bus_arbiter_pkg.sv
// Shared encodings for the I/D to core AXI3 arbiter: FSM states, grant and AXI constants.
package axi_bus_arbiter_pkg;

    typedef enum logic [1:0] {R_IDLE, R_ADDR, R_DATA} rd_state_e;
    typedef enum logic [1:0] {W_IDLE, W_DATA, W_RESP} wr_state_e;
    typedef enum logic [1:0] {GNT_NONE, GNT_I, GNT_D} gnt_e;

    localparam logic [2:0] AXI_SIZE_1B    = 3'b000;
    localparam logic [2:0] AXI_SIZE_2B    = 3'b001;
    localparam logic [2:0] AXI_SIZE_4B    = 3'b010;
    localparam logic [1:0] AXI_BURST_FIXED = 2'b00;
    localparam logic [1:0] AXI_BURST_INCR  = 2'b01;
    localparam logic [1:0] AXI_BURST_WRAP  = 2'b10;

endpackage

// File: rtl/axi_bus_arbiter_if.sv
// Full AXI3 channel bundle; master modport is the initiator side, slave the target side.
interface axi_bus_arbiter_if #(
    parameter int ID_W   = 4,
    parameter int ADDR_W = 32,
    parameter int DATA_W = 32
);
    logic [ID_W-1:0]     arid;
    logic [ADDR_W-1:0]   araddr;
    logic [3:0]          arlen;
    logic [2:0]          arsize;
    logic [1:0]          arburst;
    logic [1:0]          arlock;
    logic [3:0]          arcache;
    logic [2:0]          arprot;
    logic                arvalid;
    logic                arready;
    logic [ID_W-1:0]     rid;
    logic [DATA_W-1:0]   rdata;
    logic [1:0]          rresp;
    logic                rlast;
    logic                rvalid;
    logic                rready;
    logic [ID_W-1:0]     awid;
    logic [ADDR_W-1:0]   awaddr;
    logic [3:0]          awlen;
    logic [2:0]          awsize;
    logic [1:0]          awburst;
    logic [1:0]          awlock;
    logic [3:0]          awcache;
    logic [2:0]          awprot;
    logic                awvalid;
    logic                awready;
    logic [ID_W-1:0]     wid;
    logic [DATA_W-1:0]   wdata;
    logic [DATA_W/8-1:0] wstrb;
    logic                wlast;
    logic                wvalid;
    logic                wready;
    logic [ID_W-1:0]     bid;
    logic [1:0]          bresp;
    logic                bvalid;
    logic                bready;

    modport master (
        output arid, araddr, arlen, arsize, arburst, arlock, arcache, arprot, arvalid,
        input  arready,
        input  rid, rdata, rresp, rlast, rvalid,
        output rready,
        output awid, awaddr, awlen, awsize, awburst, awlock, awcache, awprot, awvalid,
        input  awready,
        output wid, wdata, wstrb, wlast, wvalid,
        input  wready,
        input  bid, bresp, bvalid,
        output bready
    );

    modport slave (
        input  arid, araddr, arlen, arsize, arburst, arlock, arcache, arprot, arvalid,
        output arready,
        output rid, rdata, rresp, rlast, rvalid,
        input  rready,
        input  awid, awaddr, awlen, awsize, awburst, awlock, awcache, awprot, awvalid,
        output awready,
        input  wid, wdata, wstrb, wlast, wvalid,
        output wready,
        output bid, bresp, bvalid,
        input  bready
    );

endinterface

// File: rtl/axi_bus_arbiter_rd_mux.sv
// Grant-indexed AR/R steering between the I and D read masters and the core port.
module axi_rd_mux
    import axi_bus_arbiter_pkg::*;
(
    input  rd_state_e         i_state,
    input  gnt_e              i_gnt,
    axi_bus_arbiter_if.slave  i_bus,
    axi_bus_arbiter_if.slave  d_bus,
    axi_bus_arbiter_if.master m_bus
);

    always_comb begin
        m_bus.arid    = '0;
        m_bus.araddr  = '0;
        m_bus.arlen   = '0;
        m_bus.arsize  = '0;
        m_bus.arburst = '0;
        m_bus.arlock  = '0;
        m_bus.arcache = '0;
        m_bus.arprot  = '0;
        m_bus.arvalid = 1'b0;
        m_bus.rready  = 1'b0;
        i_bus.arready = 1'b0;
        i_bus.rid     = '0;
        i_bus.rdata   = '0;
        i_bus.rresp   = '0;
        i_bus.rlast   = 1'b0;
        i_bus.rvalid  = 1'b0;
        d_bus.arready = 1'b0;
        d_bus.rid     = '0;
        d_bus.rdata   = '0;
        d_bus.rresp   = '0;
        d_bus.rlast   = 1'b0;
        d_bus.rvalid  = 1'b0;

        if (i_state == R_ADDR && i_gnt == GNT_D) begin
            m_bus.arid    = d_bus.arid;
            m_bus.araddr  = d_bus.araddr;
            m_bus.arlen   = d_bus.arlen;
            m_bus.arsize  = d_bus.arsize;
            m_bus.arburst = d_bus.arburst;
            m_bus.arlock  = d_bus.arlock;
            m_bus.arcache = d_bus.arcache;
            m_bus.arprot  = d_bus.arprot;
            m_bus.arvalid = d_bus.arvalid;
            d_bus.arready = m_bus.arready;
        end else if (i_state == R_ADDR && i_gnt == GNT_I) begin
            m_bus.arid    = i_bus.arid;
            m_bus.araddr  = i_bus.araddr;
            m_bus.arlen   = i_bus.arlen;
            m_bus.arsize  = i_bus.arsize;
            m_bus.arburst = i_bus.arburst;
            m_bus.arlock  = i_bus.arlock;
            m_bus.arcache = i_bus.arcache;
            m_bus.arprot  = i_bus.arprot;
            m_bus.arvalid = i_bus.arvalid;
            i_bus.arready = m_bus.arready;
        end

        // Read data follows the registered grant only; rid is never used for routing.
        if (i_state == R_DATA && i_gnt == GNT_D) begin
            d_bus.rid    = m_bus.rid;
            d_bus.rdata  = m_bus.rdata;
            d_bus.rresp  = m_bus.rresp;
            d_bus.rlast  = m_bus.rlast;
            d_bus.rvalid = m_bus.rvalid;
            m_bus.rready = d_bus.rready;
        end else if (i_state == R_DATA && i_gnt == GNT_I) begin
            i_bus.rid    = m_bus.rid;
            i_bus.rdata  = m_bus.rdata;
            i_bus.rresp  = m_bus.rresp;
            i_bus.rlast  = m_bus.rlast;
            i_bus.rvalid = m_bus.rvalid;
            m_bus.rready = i_bus.rready;
        end
    end

endmodule

// File: rtl/axi_bus_arbiter.sv
// Merges I-cache (read-only) and D-cache AXI3 masters onto the core port.
// Define AXI_ARB_RR_EN for round-robin read arbitration instead of fixed D-over-I priority.
module axi_bus_arbiter
    import axi_bus_arbiter_pkg::*;
#(
    parameter int ID_W   = 4,
    parameter int ADDR_W = 32,
    parameter int DATA_W = 32
) (
    input  logic              aclk,
    input  logic              aresetn,
    axi_bus_arbiter_if.slave  i_bus,
    axi_bus_arbiter_if.slave  d_bus,
    axi_bus_arbiter_if.master m_bus,
    output logic              arb_err
);

    rd_state_e       r_rd_state, w_rd_state_nxt;
    wr_state_e       r_wr_state, w_wr_state_nxt;
    gnt_e            r_gnt, w_gnt_nxt;
    logic [ID_W-1:0] r_arid, r_awid;
    logic [3:0]      r_awlen, r_beat;
    logic            w_pick_d, w_ar_hs, w_r_hs, w_aw_hs, w_w_hs, w_b_hs, w_err_set;

    axi_rd_mux u_rd_mux (
        .i_state (r_rd_state),
        .i_gnt   (r_gnt),
        .i_bus   (i_bus),
        .d_bus   (d_bus),
        .m_bus   (m_bus)
    );

    assign w_ar_hs = m_bus.arvalid && m_bus.arready;
    assign w_r_hs  = m_bus.rvalid && m_bus.rready;
    assign w_aw_hs = m_bus.awvalid && m_bus.awready;
    assign w_w_hs  = m_bus.wvalid && m_bus.wready;
    assign w_b_hs  = (r_wr_state == W_RESP) && m_bus.bvalid && d_bus.bready;

`ifdef AXI_ARB_RR_EN
    logic r_last_d;

    assign w_pick_d = d_bus.arvalid && (!i_bus.arvalid || !r_last_d);

    always_ff @(posedge aclk or negedge aresetn) begin
        if (!aresetn)
            r_last_d <= 1'b0;
        else if (r_rd_state == R_IDLE && (d_bus.arvalid || i_bus.arvalid))
            r_last_d <= w_pick_d;
    end
`else
    assign w_pick_d = d_bus.arvalid;
`endif

    always_comb begin
        w_rd_state_nxt = r_rd_state;
        w_gnt_nxt      = r_gnt;
        case (r_rd_state)
            R_IDLE: if (d_bus.arvalid || i_bus.arvalid) begin
                w_gnt_nxt      = w_pick_d ? GNT_D : GNT_I;
                w_rd_state_nxt = R_ADDR;
            end
            R_ADDR: if (w_ar_hs) w_rd_state_nxt = R_DATA;
            R_DATA: if (w_r_hs && m_bus.rlast) begin
                w_rd_state_nxt = R_IDLE;
                w_gnt_nxt      = GNT_NONE;
            end
            default: begin
                w_rd_state_nxt = R_IDLE;
                w_gnt_nxt      = GNT_NONE;
            end
        endcase
    end

    always_ff @(posedge aclk or negedge aresetn) begin
        if (!aresetn) begin
            r_rd_state <= R_IDLE;
            r_gnt      <= GNT_NONE;
            r_arid     <= '0;
        end else begin
            r_rd_state <= w_rd_state_nxt;
            r_gnt      <= w_gnt_nxt;
            if (w_ar_hs) r_arid <= m_bus.arid;
        end
    end

    always_comb begin
        w_wr_state_nxt = r_wr_state;
        m_bus.awid     = '0;
        m_bus.awaddr   = '0;
        m_bus.awlen    = '0;
        m_bus.awsize   = '0;
        m_bus.awburst  = '0;
        m_bus.awlock   = '0;
        m_bus.awcache  = '0;
        m_bus.awprot   = '0;
        m_bus.awvalid  = 1'b0;
        m_bus.wid      = '0;
        m_bus.wdata    = '0;
        m_bus.wstrb    = '0;
        m_bus.wlast    = 1'b0;
        m_bus.wvalid   = 1'b0;
        m_bus.bready   = 1'b0;
        d_bus.awready  = 1'b0;
        d_bus.wready   = 1'b0;
        d_bus.bid      = '0;
        d_bus.bresp    = '0;
        d_bus.bvalid   = 1'b0;
        case (r_wr_state)
            // Idle passthrough is the only state-independent path, so it is gated by reset.
            W_IDLE: if (aresetn) begin
                m_bus.awid    = d_bus.awid;
                m_bus.awaddr  = d_bus.awaddr;
                m_bus.awlen   = d_bus.awlen;
                m_bus.awsize  = d_bus.awsize;
                m_bus.awburst = d_bus.awburst;
                m_bus.awlock  = d_bus.awlock;
                m_bus.awcache = d_bus.awcache;
                m_bus.awprot  = d_bus.awprot;
                m_bus.awvalid = d_bus.awvalid;
                d_bus.awready = m_bus.awready;
                if (d_bus.awvalid && m_bus.awready) w_wr_state_nxt = W_DATA;
            end
            W_DATA: begin
                m_bus.wid    = d_bus.wid;
                m_bus.wdata  = d_bus.wdata;
                m_bus.wstrb  = d_bus.wstrb;
                m_bus.wlast  = d_bus.wlast;
                m_bus.wvalid = d_bus.wvalid;
                d_bus.wready = m_bus.wready;
                if (w_w_hs && r_beat == r_awlen) w_wr_state_nxt = W_RESP;
            end
            W_RESP: begin
                d_bus.bid    = m_bus.bid;
                d_bus.bresp  = m_bus.bresp;
                d_bus.bvalid = m_bus.bvalid;
                m_bus.bready = d_bus.bready;
                if (w_b_hs) w_wr_state_nxt = W_IDLE;
            end
            default: w_wr_state_nxt = W_IDLE;
        endcase
    end

    always_ff @(posedge aclk or negedge aresetn) begin
        if (!aresetn) begin
            r_wr_state <= W_IDLE;
            r_awlen    <= '0;
            r_awid     <= '0;
            r_beat     <= '0;
        end else begin
            r_wr_state <= w_wr_state_nxt;
            if (w_aw_hs) begin
                r_awlen <= d_bus.awlen;
                r_awid  <= d_bus.awid;
                r_beat  <= '0;
            end else if (w_w_hs) begin
                r_beat  <= r_beat + 4'd1;
            end
        end
    end

    assign w_err_set = (w_r_hs && m_bus.rid != r_arid)
                    || (w_w_hs && (d_bus.wlast != (r_beat == r_awlen)))
                    || (w_b_hs && m_bus.bid != r_awid);

    always_ff @(posedge aclk or negedge aresetn) begin
        if (!aresetn)
            arb_err <= 1'b0;
        else if (w_err_set)
            arb_err <= 1'b1;
    end

    // The I-cache never writes: its write channels are tied off.
    assign i_bus.awready = 1'b0;
    assign i_bus.wready  = 1'b0;
    assign i_bus.bid     = '0;
    assign i_bus.bresp   = '0;
    assign i_bus.bvalid  = 1'b0;

    logic [ADDR_W-1:0] w_unused_awaddr;
    logic [DATA_W-1:0] w_unused_wdata;
    logic              w_unused_misc;
    assign w_unused_awaddr = i_bus.awaddr;
    assign w_unused_wdata  = i_bus.wdata;
    assign w_unused_misc   = ^{i_bus.awid, i_bus.awlen, i_bus.awsize, i_bus.awburst,
                               i_bus.awlock, i_bus.awcache, i_bus.awprot, i_bus.awvalid,
                               i_bus.wid, i_bus.wstrb, i_bus.wlast, i_bus.wvalid, i_bus.bready};

endmodule
